// File: rtl/block_beat_sequencer_pkg.sv
// Shared types and parameter helpers for the cache-block beat sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package block_beat_sequencer_pkg;

  // Sequencer states; GAP is the single re-arm cycle between beats
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_BEAT,
    ST_WRITE_BEAT,
    ST_GAP,
    ST_DONE
  } state_t;

  // Number of bus beats needed to move one cache block
  function automatic int beats_f(input int block_width, input int beat_width);
    return block_width / beat_width;
  endfunction

  // Byte stride between consecutive beat addresses
  function automatic int beat_bytes_f(input int beat_width);
    return beat_width / 8;
  endfunction

  // Address bits inside one block; cleared to form the block base address
  function automatic int offset_bits_f(input int block_width);
    return $clog2(block_width / 8);
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit
  function automatic int width_min1_f(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/block_beat_sequencer_beat_retry_tracker.sv
// Beat index (k) and per-beat retry count (r) for the block sequencer.
// Latency: counters update on the edge that samples the qualified beat result.
// Backpressure: none; the parent only pulses ok/fault while a beat is in flight.
module block_beat_sequencer_beat_retry_tracker #(
  parameter int BEATS       = 4,
  parameter int MAX_RETRIES = 2,
  parameter int K_W         = 2,
  parameter int R_W         = 2
) (
  input  logic           i_clk,
  input  logic           i_arst,
  input  logic           i_clear,
  input  logic           i_beat_ok,
  input  logic           i_beat_fault,
  output logic [K_W-1:0] o_k,
  output logic           o_last_beat,
  output logic           o_retries_exhausted
);

  logic [R_W-1:0] r;

  assign o_last_beat         = (o_k == K_W'(BEATS - 1));
  assign o_retries_exhausted = (r == R_W'(MAX_RETRIES));

  // Advance k on success (holding at the last beat), count retries on faults
  always_ff @(posedge i_clk) begin
    if (i_arst || i_clear) begin
      o_k <= '0;
      r   <= '0;
    end else if (i_beat_ok) begin
      r <= '0;
      if (!o_last_beat) begin
        o_k <= o_k + K_W'(1);
      end
    end else if (i_beat_fault && !o_retries_exhausted) begin
      r <= r + R_W'(1);
    end
  end

endmodule

// File: rtl/block_beat_sequencer.sv
// Splits a cache block into sequential bus beats, retries faulted beats, assembles reads.
// Latency: beat start one cycle after acceptance; 2*BEATS cycles to o_done when beats succeed first try.
// Backpressure: waits indefinitely on i_beat_done; start requests are ignored while busy.
module block_beat_sequencer
  import block_beat_sequencer_pkg::*;
#(
  parameter int BLOCK_WIDTH = 128,
  parameter int BEAT_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 64,
  parameter int MAX_RETRIES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_start_read,
  input  logic                   i_start_write,
  input  logic [ADDR_WIDTH-1:0]  i_addr_block,
  input  logic [BLOCK_WIDTH-1:0] i_data_block,
  output logic [BLOCK_WIDTH-1:0] o_data_block,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error,
  output logic                   o_beat_start_read,
  output logic                   o_beat_start_write,
  output logic [ADDR_WIDTH-1:0]  o_beat_addr,
  output logic [BEAT_WIDTH-1:0]  o_beat_data,
  input  logic [BEAT_WIDTH-1:0]  i_beat_data,
  input  logic                   i_beat_done,
  input  logic                   i_beat_fault
);

  localparam int BEATS       = beats_f(BLOCK_WIDTH, BEAT_WIDTH);
  localparam int BEAT_BYTES  = beat_bytes_f(BEAT_WIDTH);
  localparam int OFFSET_BITS = offset_bits_f(BLOCK_WIDTH);
  localparam int K_W         = width_min1_f(BEATS);
  localparam int R_W         = width_min1_f(MAX_RETRIES + 1);

  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;
  localparam logic [ADDR_WIDTH-1:0] BEAT_STRIDE = ADDR_WIDTH'(BEAT_BYTES);

  state_t                 state;
  logic                   mode_write;
  logic                   err_flag;
  logic [ADDR_WIDTH-1:0]  base_addr;
  logic [BLOCK_WIDTH-1:0] wr_block;
  logic [BLOCK_WIDTH-1:0] rd_block;
  logic                   start_rd_q;
  logic                   start_wr_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   error_q;
  logic [BEAT_WIDTH-1:0]  beat_wdata;

  logic [K_W-1:0]         k;
  logic                   last_beat;
  logic                   retries_exhausted;
  logic                   in_beat;
  logic                   accept;
  logic                   beat_ok;
  logic                   beat_fault;

  // Beat results only count while a beat request is outstanding
  assign in_beat    = (state == ST_READ_BEAT) || (state == ST_WRITE_BEAT);
  assign accept     = (state == ST_IDLE) && (i_start_read || i_start_write);
  assign beat_ok    = in_beat && i_beat_done && !i_beat_fault;
  assign beat_fault = in_beat && i_beat_done && i_beat_fault;

  block_beat_sequencer_beat_retry_tracker #(
    .BEATS       (BEATS),
    .MAX_RETRIES (MAX_RETRIES),
    .K_W         (K_W),
    .R_W         (R_W)
  ) u_beat_retry_tracker (
    .i_clk               (i_clk),
    .i_arst              (i_arst),
    .i_clear             (accept),
    .i_beat_ok           (beat_ok),
    .i_beat_fault        (beat_fault),
    .o_k                 (k),
    .o_last_beat         (last_beat),
    .o_retries_exhausted (retries_exhausted)
  );

  // Select the write beat for the current index; beat 0 is the least significant slice
  always_comb begin
    beat_wdata = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (k == K_W'(b)) begin
        beat_wdata = wr_block[b*BEAT_WIDTH +: BEAT_WIDTH];
      end
    end
  end

  // Block state machine with registered handshake outputs and read-block assembly
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state      <= ST_IDLE;
      mode_write <= 1'b0;
      err_flag   <= 1'b0;
      base_addr  <= '0;
      wr_block   <= '0;
      rd_block   <= '0;
      start_rd_q <= 1'b0;
      start_wr_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start_read || i_start_write) begin
            base_addr <= i_addr_block & OFFSET_MASK;
            busy_q    <= 1'b1;
            // A simultaneous write request is dropped in favour of the read
            if (i_start_read) begin
              mode_write <= 1'b0;
              start_rd_q <= 1'b1;
              state      <= ST_READ_BEAT;
            end else begin
              mode_write <= 1'b1;
              wr_block   <= i_data_block;
              start_wr_q <= 1'b1;
              state      <= ST_WRITE_BEAT;
            end
          end
        end

        ST_READ_BEAT, ST_WRITE_BEAT: begin
          if (i_beat_done) begin
            start_rd_q <= 1'b0;
            start_wr_q <= 1'b0;
            if (!i_beat_fault) begin
              if (!mode_write) begin
                for (int b = 0; b < BEATS; b++) begin
                  if (k == K_W'(b)) begin
                    rd_block[b*BEAT_WIDTH +: BEAT_WIDTH] <= i_beat_data;
                  end
                end
              end
              if (last_beat) begin
                done_q  <= 1'b1;
                error_q <= err_flag;
                state   <= ST_DONE;
              end else begin
                state <= ST_GAP;
              end
            end else if (!retries_exhausted) begin
              state <= ST_GAP;
            end else begin
              // Out of retries: abandon the remaining beats and report the abort
              err_flag <= 1'b1;
              done_q   <= 1'b1;
              error_q  <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end

        ST_GAP: begin
          if (mode_write) begin
            start_wr_q <= 1'b1;
            state      <= ST_WRITE_BEAT;
          end else begin
            start_rd_q <= 1'b1;
            state      <= ST_READ_BEAT;
          end
        end

        ST_DONE: begin
          busy_q   <= 1'b0;
          err_flag <= 1'b0;
          state    <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_data_block       = rd_block;
  assign o_busy             = busy_q;
  assign o_done             = done_q;
  assign o_error            = error_q;
  assign o_beat_start_read  = start_rd_q;
  assign o_beat_start_write = start_wr_q;
  assign o_beat_addr        = base_addr + (ADDR_WIDTH'(k) * BEAT_STRIDE);
  assign o_beat_data        = beat_wdata;

endmodule

// File: tb/tb_block_beat_sequencer.sv
// Directed bench for block_beat_sequencer: default 128/32 instance plus a 256/64 instance.
// Latency: checks are placed on exact cycles relative to block acceptance.
// Backpressure: the bench acts as a bus master that completes each beat in its first start cycle.
module tb_block_beat_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default-parameter instance (128-bit block, 32-bit beats)
  logic         a_arst, a_start_read, a_start_write;
  logic [63:0]  a_addr;
  logic [127:0] a_data_in, a_data_out;
  logic         a_busy, a_done, a_error, a_bsr, a_bsw;
  logic [63:0]  a_baddr;
  logic [31:0]  a_bdata, a_bdin;
  logic         a_bdone, a_bfault;

  // Wide instance (256-bit block, 64-bit beats)
  logic         b_arst, b_start_read, b_start_write;
  logic [63:0]  b_addr;
  logic [255:0] b_data_in, b_data_out;
  logic         b_busy, b_done, b_error, b_bsr, b_bsw;
  logic [63:0]  b_baddr;
  logic [63:0]  b_bdata, b_bdin;
  logic         b_bdone, b_bfault;

  block_beat_sequencer dut_a (
    .i_clk(clk), .i_arst(a_arst), .i_start_read(a_start_read), .i_start_write(a_start_write),
    .i_addr_block(a_addr), .i_data_block(a_data_in), .o_data_block(a_data_out),
    .o_busy(a_busy), .o_done(a_done), .o_error(a_error),
    .o_beat_start_read(a_bsr), .o_beat_start_write(a_bsw), .o_beat_addr(a_baddr),
    .o_beat_data(a_bdata), .i_beat_data(a_bdin), .i_beat_done(a_bdone), .i_beat_fault(a_bfault)
  );

  block_beat_sequencer #(.BLOCK_WIDTH(256), .BEAT_WIDTH(64), .ADDR_WIDTH(64), .MAX_RETRIES(2)) dut_b (
    .i_clk(clk), .i_arst(b_arst), .i_start_read(b_start_read), .i_start_write(b_start_write),
    .i_addr_block(b_addr), .i_data_block(b_data_in), .o_data_block(b_data_out),
    .o_busy(b_busy), .o_done(b_done), .o_error(b_error),
    .o_beat_start_read(b_bsr), .o_beat_start_write(b_bsw), .o_beat_addr(b_baddr),
    .o_beat_data(b_bdata), .i_beat_data(b_bdin), .i_beat_done(b_bdone), .i_beat_fault(b_bfault)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One beat on the default instance: check request, complete it, check the start drops
  task automatic beat_a(input string tag, input bit wr, input logic [63:0] exp_addr,
                        input logic [31:0] exp_wdata, input logic [31:0] rdata, input bit fault);
    chk({tag, ".start"}, wr ? a_bsw : a_bsr, 1);
    chk({tag, ".other"}, wr ? a_bsr : a_bsw, 0);
    chk({tag, ".addr"}, a_baddr, exp_addr);
    chk({tag, ".nodone"}, a_done, 0);
    if (wr) chk({tag, ".wdata"}, a_bdata, exp_wdata);
    a_bdone = 1'b1; a_bfault = fault; a_bdin = rdata;
    step();
    a_bdone = 1'b0; a_bfault = 1'b0; a_bdin = '0;
    chk({tag, ".drop"}, a_bsr | a_bsw, 0);
  endtask

  // One read beat on the wide instance
  task automatic beat_b(input string tag, input logic [63:0] exp_addr, input logic [63:0] rdata);
    chk({tag, ".start"}, b_bsr, 1);
    chk({tag, ".addr"}, b_baddr, exp_addr);
    b_bdone = 1'b1; b_bfault = 1'b0; b_bdin = rdata;
    step();
    b_bdone = 1'b0; b_bdin = '0;
    chk({tag, ".drop"}, b_bsr, 0);
  endtask

  initial begin
    a_arst = 1'b1; a_start_read = 1'b0; a_start_write = 1'b0; a_addr = '0; a_data_in = '0;
    a_bdin = '0; a_bdone = 1'b0; a_bfault = 1'b0;
    b_arst = 1'b1; b_start_read = 1'b0; b_start_write = 1'b0; b_addr = '0; b_data_in = '0;
    b_bdin = '0; b_bdone = 1'b0; b_bfault = 1'b0;
    repeat (3) step();

    // Reset state: every output low
    chk("rst.a.data", a_data_out, 0);
    chk("rst.a.ctl", {a_busy, a_done, a_error, a_bsr, a_bsw}, 0);
    chk("rst.a.addr", a_baddr, 0);
    chk("rst.a.bdata", a_bdata, 0);
    chk("rst.b.data", b_data_out, 0);
    chk("rst.b.ctl", {b_busy, b_done, b_error, b_bsr, b_bsw}, 0);
    chk("rst.b.addr", b_baddr, 0);
    a_arst = 1'b0; b_arst = 1'b0;
    step();

    // T1: read of unaligned block address, four clean beats
    a_start_read = 1'b1; a_addr = 64'h1000_0013;
    step();
    a_start_read = 1'b0; a_addr = '0;
    chk("t1.busy", a_busy, 1);
    beat_a("t1.b0", 0, 64'h1000_0010, 0, 32'hA0, 0); step();
    beat_a("t1.b1", 0, 64'h1000_0014, 0, 32'hA1, 0); step();
    beat_a("t1.b2", 0, 64'h1000_0018, 0, 32'hA2, 0); step();
    beat_a("t1.b3", 0, 64'h1000_001C, 0, 32'hA3, 0);
    chk("t1.done", a_done, 1);
    chk("t1.error", a_error, 0);
    chk("t1.busy_done", a_busy, 1);
    chk("t1.data", a_data_out, 128'h000000A3_000000A2_000000A1_000000A0);
    step();
    chk("t1.done_pulse", a_done, 0);
    chk("t1.idle", a_busy, 0);

    // T2: write block, beats leave least significant slice first
    a_start_write = 1'b1; a_addr = 64'h2000;
    a_data_in = 128'h44444444_33333333_22222222_11111111;
    step();
    a_start_write = 1'b0; a_data_in = '0;
    beat_a("t2.b0", 1, 64'h2000, 32'h11111111, 0, 0); step();
    beat_a("t2.b1", 1, 64'h2004, 32'h22222222, 0, 0); step();
    beat_a("t2.b2", 1, 64'h2008, 32'h33333333, 0, 0); step();
    beat_a("t2.b3", 1, 64'h200C, 32'h44444444, 0, 0);
    chk("t2.done", a_done, 1);
    chk("t2.error", a_error, 0);
    chk("t2.rdata_kept", a_data_out, 128'h000000A3_000000A2_000000A1_000000A0);
    step();

    // T3: beat 1 faults twice then succeeds at the same address
    a_start_read = 1'b1; a_addr = 64'h3000;
    step();
    a_start_read = 1'b0;
    beat_a("t3.b0", 0, 64'h3000, 0, 32'hB0, 0); step();
    beat_a("t3.b1f1", 0, 64'h3004, 0, 32'hDEAD0001, 1); step();
    beat_a("t3.b1f2", 0, 64'h3004, 0, 32'hDEAD0002, 1); step();
    beat_a("t3.b1ok", 0, 64'h3004, 0, 32'hB1, 0); step();
    beat_a("t3.b2", 0, 64'h3008, 0, 32'hB2, 0); step();
    beat_a("t3.b3", 0, 64'h300C, 0, 32'hB3, 0);
    chk("t3.done", a_done, 1);
    chk("t3.error", a_error, 0);
    chk("t3.data", a_data_out, 128'h000000B3_000000B2_000000B1_000000B0);
    step();

    // T4: beat 2 faults three times, block aborts and beat 3 never starts
    a_start_read = 1'b1; a_addr = 64'h4000;
    step();
    a_start_read = 1'b0;
    beat_a("t4.b0", 0, 64'h4000, 0, 32'hC0, 0); step();
    beat_a("t4.b1", 0, 64'h4004, 0, 32'hC1, 0); step();
    beat_a("t4.b2f1", 0, 64'h4008, 0, 32'hEE, 1); step();
    beat_a("t4.b2f2", 0, 64'h4008, 0, 32'hEE, 1); step();
    beat_a("t4.b2f3", 0, 64'h4008, 0, 32'hEE, 1);
    chk("t4.done", a_done, 1);
    chk("t4.error", a_error, 1);
    chk("t4.data", a_data_out, 128'h000000B3_000000B2_000000C1_000000C0);
    step();
    chk("t4.done_pulse", a_done, 0);
    chk("t4.error_pulse", a_error, 0);
    chk("t4.idle", {a_busy, a_bsr, a_bsw}, 0);

    // T5: back-to-back request with read and write together; starts while busy are ignored
    a_start_read = 1'b1; a_start_write = 1'b1; a_addr = 64'h5000; a_data_in = {4{32'h5A5A5A5A}};
    step();
    a_start_read = 1'b0; a_start_write = 1'b0; a_data_in = '0;
    beat_a("t5.b0", 0, 64'h5000, 0, 32'hD0, 0);
    a_start_write = 1'b1; a_addr = 64'h9000;
    step();
    a_start_write = 1'b0; a_start_read = 1'b1;
    beat_a("t5.b1", 0, 64'h5004, 0, 32'hD1, 0);
    a_start_read = 1'b0;
    step();
    beat_a("t5.b2", 0, 64'h5008, 0, 32'hD2, 0); step();
    beat_a("t5.b3", 0, 64'h500C, 0, 32'hD3, 0);
    chk("t5.done", a_done, 1);
    chk("t5.error", a_error, 0);
    chk("t5.data", a_data_out, 128'h000000D3_000000D2_000000D1_000000D0);
    step();
    chk("t5.after1", {a_done, a_busy}, 0);
    step();
    chk("t5.after2", {a_done, a_busy, a_bsr, a_bsw}, 0);

    // T6: wide instance, reset pulsed during beat 2, then a fresh read
    b_start_read = 1'b1; b_addr = 64'h6000_0007;
    step();
    b_start_read = 1'b0; b_addr = '0;
    beat_b("t6.b0", 64'h6000_0000, 64'hE0); step();
    beat_b("t6.b1", 64'h6000_0008, 64'hE1); step();
    chk("t6.b2.start", b_bsr, 1);
    chk("t6.b2.addr", b_baddr, 64'h6000_0010);
    b_arst = 1'b1;
    step();
    b_arst = 1'b0;
    chk("t6.rst.data", b_data_out, 0);
    chk("t6.rst.ctl", {b_busy, b_done, b_error, b_bsr, b_bsw}, 0);
    chk("t6.rst.addr", b_baddr, 0);
    chk("t6.rst.bdata", b_bdata, 0);
    step();
    chk("t6.nodone", {b_done, b_busy}, 0);
    b_start_read = 1'b1; b_addr = 64'h7000;
    step();
    b_start_read = 1'b0;
    beat_b("t6.r0", 64'h7000, 64'h1111_0000_0000_00F0); step();
    beat_b("t6.r1", 64'h7008, 64'h2222_0000_0000_00F1); step();
    beat_b("t6.r2", 64'h7010, 64'h3333_0000_0000_00F2); step();
    beat_b("t6.r3", 64'h7018, 64'h4444_0000_0000_00F3);
    chk("t6.done", b_done, 1);
    chk("t6.error", b_error, 0);
    chk("t6.data", b_data_out,
        {64'h4444_0000_0000_00F3, 64'h3333_0000_0000_00F2, 64'h2222_0000_0000_00F1, 64'h1111_0000_0000_00F0});
    step();
    chk("t6.done_pulse", {b_done, b_busy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_beat_sequencer.md
# block_beat_sequencer

Parametrised cache-block transfer sequencer between the cache refill/write-back path and a single-beat bus master (AXI4-Lite top). It splits a BLOCK_WIDTH block into BEATS = BLOCK_WIDTH/BEAT_WIDTH sequential beats, generates per-beat addresses, and assembles read beats into a block. It supports any beat width, retries faulted beats, reports errors, and produces a single done pulse per block.

## Interface
- BLOCK_WIDTH, 128: cache block width in bits; integer multiple of BEAT_WIDTH; power of two.
- BEAT_WIDTH, 32: bus beat width in bits; power of two, ≥ 8.
- ADDR_WIDTH, 64: address width.
- MAX_RETRIES, 2: retries per beat after a fault before aborting; 0 means no retry.
- i_clk  in  1  clock; all logic on the rising edge.
- i_arst  in  1  reset; synchronous, active-high.
- i_start_read  in  1  block read request; sampled in IDLE only.
- i_start_write  in  1  block write request; sampled in IDLE only.
- i_addr_block  in  ADDR_WIDTH  block address; offset bits are ignored.
- i_data_block  in  BLOCK_WIDTH  write block; latched on acceptance.
- o_data_block  out  BLOCK_WIDTH  assembled read block.
- o_busy  out  1  high from acceptance through the DONE cycle.
- o_done  out  1  one-cycle pulse at the end of a block.
- o_error  out  1  one-cycle pulse with o_done when the block aborted.
- o_beat_start_read / o_beat_start_write  out  1  per-beat request to the bus master; level.
- o_beat_addr  out  ADDR_WIDTH  current beat address.
- o_beat_data  out  BEAT_WIDTH  current write beat.
- i_beat_data  in  BEAT_WIDTH  read beat; valid with i_beat_done.
- i_beat_done  in  1  beat complete.
- i_beat_fault  in  1  beat failed; meaningful only with i_beat_done.

## Operation
- States are IDLE, READ_BEAT, WRITE_BEAT, GAP and DONE.
- **IDLE**
  - On i_start_read, latch the base address = i_addr_block with the low log2(BLOCK_WIDTH/8) bits cleared. Set beat index k=0 and retry count r=0, then go to READ_BEAT.
  - i_start_write does the same and also latches i_data_block, then goes to WRITE_BEAT.
  - If both are high, read wins; the write is dropped.
- **READ_BEAT / WRITE_BEAT**
  - The matching o_beat_start_* is held high.
  - o_beat_addr = base + k·(BEAT_WIDTH/8).
  - o_beat_data = latched block[k·BEAT_WIDTH +: BEAT_WIDTH], so beat 0 is the least significant beat.
  - On i_beat_done without a fault: a read stores i_beat_data into o_data_block slice k. Then go to GAP with k+1, or to DONE if k = BEATS−1. r is cleared.
  - On i_beat_done with a fault and r < MAX_RETRIES: r+1, same k, go to GAP, and the slice is not written.
  - On i_beat_done with a fault and r = MAX_RETRIES: set an error flag and go to DONE; the remaining beats are skipped.
- **GAP**: both beat starts are low for exactly one cycle, then return to the same mode's BEAT state. This lets the bus master re-arm.
- **DONE**: o_done=1 and o_error=error flag for one cycle, then go to IDLE and clear the flag.
- o_data_block holds its value until it is overwritten by a later read beat. On an aborted read, the slices already written keep their new data.
- Inputs ignored:
  - i_beat_done in IDLE, GAP or DONE.
  - Start requests while busy.
- **Reset**, asserted in any state, mid-block included:
  - Next state is IDLE.
  - k, r, the error flag, o_data_block and the latched data are all 0.
  - No o_done is issued for the interrupted block.

## Timing
- Reset values: every output is 0.
- Request sampled at edge 0 → first beat start high in cycle 1.
- Beat start rises the cycle after entry to the BEAT state and falls the cycle after i_beat_done.
- If every beat completes in its first start-high cycle, a block takes 2·BEATS cycles from acceptance to the o_done cycle. That is 8 cycles for the 128/32 defaults.
- o_done is asserted the cycle after the final i_beat_done.
- o_data_block is updated at the edge sampling i_beat_done, so it is complete in the o_done cycle.
- A new request may be accepted the cycle after DONE (back-to-back gap of one idle cycle).
- Address arithmetic is modulo 2^ADDR_WIDTH. No block crosses an alignment boundary.

## Structure
- Package block_beat_sequencer_pkg holds:
  - the state enum (IDLE, READ_BEAT, WRITE_BEAT, GAP, DONE);
  - helper functions for BEATS, BEAT_BYTES and OFFSET_BITS given the parameters.
- Derived widths: $clog2(BEATS) for k and $clog2(MAX_RETRIES+1) for r; each is at least 1 bit.
- One sub-module is natural: beat_retry_tracker. It holds k and r and exposes last_beat and retries_exhausted.

## Test plan
- Default parameters, read of block address 0x1000_0013, bus returns done one cycle after each start with data 0xA0,0xA1,0xA2,0xA3:
  - beat addresses are 0x1000_0010/14/18/1C;
  - o_data_block = 0x000000A3_000000A2_000000A1_000000A0;
  - o_done arrives 8 cycles after acceptance, with o_error=0.
- Write of 0x44444444_33333333_22222222_11111111 to 0x2000 → o_beat_data sequence 0x11111111, 0x22222222, 0x33333333, 0x44444444; each start drops for one cycle after every done.
- MAX_RETRIES=2, fault on beat 1 twice then success → beat 1 is issued 3 times at the same address; o_done with o_error=0.
- Fault on beat 2 three times → beat 3 is never issued; o_done with o_error=1; slices 0–1 updated, slices 2–3 unchanged.
- Read and write asserted together in IDLE → only read beats appear. A start pulsed during a block is ignored, with exactly one o_done.
- BEAT_WIDTH=64, BLOCK_WIDTH=256; i_arst pulsed during beat 2 → all outputs are 0 the next cycle and there is no o_done. A fresh read then completes in 8 cycles.
